// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operand widths, shift op encodings and
// the decoded shift request consumed by the shifter.
package alu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SLLV = 2'b10,
        OP_SRLV = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic               left_right;
        logic [SHAMT_W-1:0] shamt;
        logic [WIDTH-1:0]   sft_src;
    } shift_req_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of a shift request into the shifter's control form.
module shift_decode
    import alu_pkg::*;
(
    input  logic [1:0]         op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   rs_i,
    input  logic [WIDTH-1:0]   rt_i,
    output shift_req_t         req_o
);

    shift_op_e op;
    logic      unused_rs_hi;

    assign op = shift_op_e'(op_i);

    // Only the low SHAMT_W bits of rs select a variable amount.
    assign unused_rs_hi = ^rs_i[WIDTH-1:SHAMT_W];

    always_comb begin
        // NOTE: default every field first so no path through the block can infer a latch.
        req_o            = '0;
        req_o.sft_src    = rt_i;
        req_o.left_right = (op == OP_SRL) || (op == OP_SRLV);
        req_o.shamt      = ((op == OP_SLLV) || (op == OP_SRLV)) ? rs_i[SHAMT_W-1:0] : shamt_i;
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the combinational shifter.
// Define SHIFT_ISSUE_SKID_EN for a two-entry build with a registered in_ready_o.
module shift_issue_stage
    import alu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   rs_i,
    input  logic [WIDTH-1:0]   rt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               left_right_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [WIDTH-1:0]   sft_src_o,
    output logic [15:0]        issue_cnt_o
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e     state_q;
    logic       valid_q;
    shift_req_t dec_req;
    shift_req_t main_q;
    logic       in_xfer;
    logic       out_xfer;
    logic [15:0] cnt_q;

    shift_decode u_decode (
        .op_i    (op_i),
        .shamt_i (shamt_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .req_o   (dec_req)
    );

    assign in_xfer  = in_valid_i && in_ready_o && !flush_i;
    assign out_xfer = valid_q && out_ready_i && !flush_i;

`ifdef SHIFT_ISSUE_SKID_EN
    shift_req_t skid_q;
    logic       ready_q;

    assign in_ready_o = ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: skid_q holds data only and is never visible unless state_q says FULL, so it needs no reset.
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: if (in_xfer) begin
                    main_q  <= dec_req;
                    valid_q <= 1'b1;
                    state_q <= ONE;
                end
                ONE: if (in_xfer && !out_xfer) begin
                    skid_q  <= dec_req;
                    ready_q <= 1'b0;
                    state_q <= FULL;
                end else if (in_xfer) begin
                    main_q  <= dec_req;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
                FULL: if (out_xfer) begin
                    main_q  <= skid_q;
                    ready_q <= 1'b1;
                    state_q <= ONE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
`else
    // Without a skid entry the slot frees in the same cycle the consumer takes it.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: if (in_xfer) begin
                    main_q  <= dec_req;
                    valid_q <= 1'b1;
                    state_q <= ONE;
                end
                ONE: if (in_xfer) begin
                    main_q  <= dec_req;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (out_xfer && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_valid_o  = valid_q;
    assign left_right_o = main_q.left_right;
    assign shamt_o      = main_q.shamt;
    assign sft_src_o    = main_q.sft_src;
    assign issue_cnt_o  = cnt_q;

endmodule
